pid_seq: RTL

PID_SEQ -- requirements
Module: pid_seq

---
 rtl/pid_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pid_seq.sv
// Power-up / rider / balance sequencer feeding the PID controller, with a sensor watchdog.
// Optional: define PID_SEQ_STEER_HYST_EN to give en_steer a release hysteresis band.
module pid_seq #(
    parameter logic [12:0] MIN_WT     = 13'h0400,
    parameter logic [11:0] DIFF_TOL   = 12'h0100,
    parameter int unsigned SETTLE_CYC = 1024,
    parameter int unsigned WDOG_CYC   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        nemo_vld,
    output logic        pid_pwr_up,
    output logic        pid_rider_off,
    output logic        pid_vld,
    output logic        en_steer,
    output logic        fault,
    output logic [1:0]  state_o
);

    localparam int unsigned SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned WCNT_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WDOG_CYC - 1);
`ifdef PID_SEQ_STEER_HYST_EN
    localparam logic [12:0] STEER_REL = 13'(DIFF_TOL) + 13'(DIFF_TOL >> 2);
`endif

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_BALANCE = 2'd3
    } state_t;

    state_t              r_state;
    logic [SCNT_W-1:0]   r_scnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_fault;
    logic                r_pid_pwr_up;
    logic                r_pid_rider_off;
    logic                r_pid_vld;
    logic                r_en_steer;

    state_t              w_state_nxt;
    logic [SCNT_W-1:0]   w_scnt_nxt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                w_fault_nxt;
    logic                w_pid_pwr_up_nxt;
    logic                w_pid_rider_off_nxt;
    logic                w_pid_vld_nxt;
    logic                w_en_steer_nxt;

    logic [12:0]         w_sum;
    logic [11:0]         w_diff;
    logic                w_rider;
    logic                w_bal;
    logic                w_wdog_exp;
    logic                w_steer_ok;

    // Load-cell conditions: rider presence and left/right balance
    assign w_sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign w_diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    assign w_rider    = (w_sum > MIN_WT);
    assign w_bal      = (w_diff < DIFF_TOL);
    assign w_wdog_exp = (r_state == ST_BALANCE) && !nemo_vld && (r_wcnt == WCNT_LAST);

`ifdef PID_SEQ_STEER_HYST_EN
    assign w_steer_ok = w_bal || (r_en_steer && ({1'b0, w_diff} < STEER_REL));
`else
    assign w_steer_ok = w_bal;
`endif

    // Next state, counters and registered output values
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = '0;
        w_wcnt_nxt  = '0;
        w_fault_nxt = r_fault;

        if (!pwr_up) begin
            w_state_nxt = ST_OFF;
            w_fault_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (!r_fault) w_state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_rider && !r_fault) w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!w_rider) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!w_bal) begin
                        w_scnt_nxt = '0;
                    end else if (r_scnt == SCNT_LAST) begin
                        w_state_nxt = ST_BALANCE;
                    end else begin
                        w_scnt_nxt = r_scnt + SCNT_W'(1);
                    end
                end
                ST_BALANCE: begin
                    // Expiry and rider drop on the same edge both land in IDLE with fault set
                    if (w_wdog_exp) w_fault_nxt = 1'b1;
                    if (!w_rider || w_wdog_exp) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!nemo_vld) begin
                        w_wcnt_nxt = (r_wcnt == WCNT_LAST) ? r_wcnt : (r_wcnt + WCNT_W'(1));
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end

        w_pid_pwr_up_nxt    = (w_state_nxt != ST_OFF);
        w_pid_rider_off_nxt = (w_state_nxt != ST_BALANCE);
        w_pid_vld_nxt       = nemo_vld && (r_state == ST_BALANCE) && (w_state_nxt == ST_BALANCE);
        w_en_steer_nxt      = (w_state_nxt == ST_BALANCE) && w_steer_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_OFF;
            r_scnt          <= '0;
            r_wcnt          <= '0;
            r_fault         <= 1'b0;
            r_pid_pwr_up    <= 1'b0;
            r_pid_rider_off <= 1'b1;
            r_pid_vld       <= 1'b0;
            r_en_steer      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_scnt          <= w_scnt_nxt;
            r_wcnt          <= w_wcnt_nxt;
            r_fault         <= w_fault_nxt;
            r_pid_pwr_up    <= w_pid_pwr_up_nxt;
            r_pid_rider_off <= w_pid_rider_off_nxt;
            r_pid_vld       <= w_pid_vld_nxt;
            r_en_steer      <= w_en_steer_nxt;
        end
    end

    assign pid_pwr_up    = r_pid_pwr_up;
    assign pid_rider_off = r_pid_rider_off;
    assign pid_vld       = r_pid_vld;
    assign en_steer      = r_en_steer;
    assign fault         = r_fault;
    assign state_o       = r_state;

endmodule
